dmem_responder: RTL and testbench
=================================

DMEM_RESPONDER -- requirements
Module: dmem_responder

Interface
REQ-001 SHALL have parameter DEPTH, default 64, number of 32-bit words in the data array (power of two, >=4).
REQ-002 SHALL have parameter LATENCY, default 2, clock edges from request acceptance to response (1..15).
REQ-003 SHALL have port clk  input  1  single clock; every flop is rising-edge.
REQ-004 SHALL have port reset  input  1  asynchronous, active-low reset.
REQ-005 SHALL have port req_valid  input  1  memory-stage request present.
REQ-006 SHALL have port req_we  input  1  1=store (STR/STRB), 0=load (LDR/LDRB).
REQ-007 SHALL have port req_byte  input  1  1=byte access, 0=word access.
REQ-008 SHALL have port req_addr  input  32  byte address (ALUResult).
REQ-009 SHALL have port req_wdata  input  32  store data (WriteData).
REQ-010 SHALL have port req_ready  output  1  request accepted this edge when high with req_valid.
REQ-011 SHALL have port rsp_valid  output  1  one-cycle response/acknowledge strobe.
REQ-012 SHALL have port rsp_rdata  output  32  load data (ReadData); zero for stores.
REQ-013 SHALL have port busy  output  1  transaction in flight; drives the hazard unit's stall.

Function
REQ-014 SHALL implement states IDLE, WAIT, RESP; req_ready=1 only in IDLE; busy=1 in WAIT and RESP.
REQ-015 SHALL accept a request on a rising edge where state=IDLE and req_valid=1, capturing we, byte, addr, wdata.
REQ-016 SHALL, on acceptance, go to RESP if LATENCY=1; otherwise go to WAIT and load the counter with LATENCY-2.
REQ-017 SHALL, in WAIT, decrement the counter each edge and go to RESP on the edge where it is 0.
REQ-018 SHALL assert rsp_valid for exactly one cycle, in RESP, beginning LATENCY edges after the accepting edge; RESP always returns to IDLE on the next edge.
REQ-019 SHALL index the array with word address addr[log2(DEPTH)+1:2]; upper bits are ignored, so addresses wrap modulo DEPTH*4.
REQ-020 SHALL ignore addr[1:0] for word accesses (forced alignment).
REQ-021 SHALL perform the array write on the edge entering RESP; a load issued immediately after it sees the new data.
REQ-022 SHALL drive rsp_rdata from the array word read on the edge entering RESP, held only while rsp_valid=1, else 0.
REQ-023 SHALL ignore req_valid while not in IDLE; input changes during WAIT/RESP do not affect the captured request.
REQ-024 SHALL perform no array access when req_valid=0 in IDLE.

Reset
REQ-025 SHALL, on reset low at any time, immediately set state=IDLE, counter=0, rsp_valid=0, rsp_rdata=0, busy=0, req_ready=1 after release.
REQ-026 SHALL abort an in-flight transaction on reset; an aborted store SHALL NOT modify the array.
REQ-027 SHALL NOT reset array contents.

Configuration
REQ-028 SHALL support macro DMEM_BYTE_EN: defined, req_byte=1 stores write only lane addr[1:0] with wdata[7:0] (little-endian) and loads return that byte zero-extended in rsp_rdata[7:0].
REQ-029 SHALL, without DMEM_BYTE_EN, ignore req_byte and treat every access as a word access.

Structure
REQ-030 SHALL place the state enum (IDLE/WAIT/RESP) and default DEPTH/LATENCY constants in shared package dmem_pkg.
REQ-031 SHALL implement the latency countdown in a sub-module dmem_lat_ctr (load, decrement, zero flag).

Verification
REQ-032 Store word 0xDEADBEEF @0x10, then load @0x10 (LATENCY=2) -> rsp_valid exactly 2 edges after each acceptance; load returns 0xDEADBEEF.
REQ-033 With DMEM_BYTE_EN: word 0x11223344 @0x20, STRB 0xAA @0x22, load word @0x20 -> 0x11AA3344; LDRB @0x23 -> 0x00000011.
REQ-034 Hold req_valid=1 continuously with different addresses (LATENCY=3) -> req_ready low in WAIT/RESP; only one request accepted per 4 cycles.
REQ-035 DEPTH=64: store 0x5 @0x100, load @0x0 -> 0x5 (wrap); load @0x3 word -> 0x5 (alignment).
REQ-036 Assert reset during WAIT of store 0x77 @0x8 over prior 0x12 -> outputs zero at once; later load @0x8 returns 0x12.
REQ-037 LATENCY=1: back-to-back requests -> rsp_valid on edge after acceptance, next acceptance one cycle after RESP.

Source files
------------

// File: rtl/dmem_pkg.sv
// Shared types and defaults for the data-memory responder.
// Build option: DMEM_BYTE_EN enables byte-lane loads/stores.
package dmem_pkg;
  typedef enum logic [1:0] {IDLE, WAIT, RESP} state_t;
  localparam int DEPTH_DEF   = 64;
  localparam int LATENCY_DEF = 2;
  localparam int CW          = 4;
endpackage

// File: rtl/dmem_lat_ctr.sv
// Latency countdown: load, decrement, zero flag.
module dmem_lat_ctr
  import dmem_pkg::*;
(
  input  logic          clk,
  input  logic          reset,
  input  logic          i_load,
  input  logic [CW-1:0] i_val,
  input  logic          i_dec,
  output logic          o_zero
);
  logic [CW-1:0] r_cnt;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_cnt <= '0;
    end else if (i_load) begin
      r_cnt <= i_val;
    end else if (i_dec && r_cnt != '0) begin
      r_cnt <= r_cnt - 1'b1;
    end
  end

  assign o_zero = (r_cnt == '0);
endmodule

// File: rtl/dmem_responder.sv
// Fixed-latency data-memory responder for the memory stage.
// Build option: DMEM_BYTE_EN enables byte-lane loads/stores.
module dmem_responder
  import dmem_pkg::*;
#(
  parameter int DEPTH   = DEPTH_DEF,
  parameter int LATENCY = LATENCY_DEF
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        req_valid,
  input  logic        req_we,
  input  logic        req_byte,
  input  logic [31:0] req_addr,
  input  logic [31:0] req_wdata,
  output logic        req_ready,
  output logic        rsp_valid,
  output logic [31:0] rsp_rdata,
  output logic        busy
);
  localparam int AW   = $clog2(DEPTH);
  localparam int LV_I = (LATENCY > 1) ? LATENCY - 2 : 0;
  localparam logic [CW-1:0] LV = LV_I[CW-1:0];

  state_t r_state;
  state_t w_next;
  logic w_acc, w_load, w_dec, w_zero, w_go;

  logic          r_we, r_byte;
  logic [AW+1:0] r_addr;
  logic [31:0]   r_wdata, r_rdata;
  logic [31:0]   r_mem [DEPTH];

  logic          w_we, w_byte, w_bsel;
  logic [AW+1:0] w_addr;
  logic [31:0]   w_wdata, w_word, w_rd;
  logic [AW-1:0] w_idx;
  logic [1:0]    w_lane;

  always_comb begin
    w_next = r_state;
    w_acc  = 1'b0;
    w_load = 1'b0;
    w_dec  = 1'b0;
    w_go   = 1'b0;
    unique case (r_state)
      IDLE: if (req_valid) begin
        w_acc = 1'b1;
        if (LATENCY == 1) begin
          w_next = RESP;
          w_go   = 1'b1;
        end else begin
          w_next = WAIT;
          w_load = 1'b1;
        end
      end
      WAIT: if (w_zero) begin
        w_next = RESP;
        w_go   = 1'b1;
      end else begin
        w_dec = 1'b1;
      end
      RESP:    w_next = IDLE;
      default: w_next = IDLE;
    endcase
  end

  dmem_lat_ctr u_ctr (
    .clk    (clk),
    .reset  (reset),
    .i_load (w_load),
    .i_val  (LV),
    .i_dec  (w_dec),
    .o_zero (w_zero)
  );

  // With LATENCY=1 the access happens on the accepting edge, so use live inputs.
  assign w_we    = (r_state == IDLE) ? req_we : r_we;
  assign w_byte  = (r_state == IDLE) ? req_byte : r_byte;
  assign w_addr  = (r_state == IDLE) ? req_addr[AW+1:0] : r_addr;
  assign w_wdata = (r_state == IDLE) ? req_wdata : r_wdata;
  assign w_idx   = w_addr[AW+1:2];
  assign w_lane  = w_addr[1:0];
  assign w_word  = r_mem[w_idx];

`ifdef DMEM_BYTE_EN
  assign w_bsel = w_byte;
  logic w_unused;
  assign w_unused = ^req_addr[31:AW+2];
`else
  assign w_bsel = 1'b0;
  logic w_unused;
  assign w_unused = ^{req_addr[31:AW+2], w_byte, w_lane};
`endif

  assign w_rd = w_bsel ? {24'h0, w_word[{w_lane, 3'b000} +: 8]} : w_word;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_state <= IDLE;
      r_we    <= 1'b0;
      r_byte  <= 1'b0;
      r_addr  <= '0;
      r_wdata <= '0;
      r_rdata <= '0;
    end else begin
      r_state <= w_next;
      if (w_acc) begin
        r_we    <= req_we;
        r_byte  <= req_byte;
        r_addr  <= req_addr[AW+1:0];
        r_wdata <= req_wdata;
      end
      if (w_go) r_rdata <= w_we ? '0 : w_rd;
    end
  end

  // Array contents survive reset; reset gating keeps aborted stores out.
  always_ff @(posedge clk) begin
    if (w_go && w_we && reset) begin
      if (w_bsel) r_mem[w_idx][{w_lane, 3'b000} +: 8] <= w_wdata[7:0];
      else        r_mem[w_idx] <= w_wdata;
    end
  end

  assign req_ready = (r_state == IDLE);
  assign busy      = (r_state != IDLE);
  assign rsp_valid = (r_state == RESP);
  assign rsp_rdata = rsp_valid ? r_rdata : '0;
endmodule

// File: tb/tb_dmem_responder.sv
// Scoreboard bench for dmem_responder at LATENCY 1, 2 and 3.
// Byte-lane expectations follow DMEM_BYTE_EN.
module tb_dmem_responder;
`ifdef DMEM_BYTE_EN
  localparam bit BE = 1'b1;
`else
  localparam bit BE = 1'b0;
`endif

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst_n [3];
  logic        req_valid [3], req_we [3], req_byte [3];
  logic [31:0] req_addr [3], req_wdata [3];
  logic        req_ready [3], rsp_valid [3], busy [3];
  logic [31:0] rsp_rdata [3];

  for (genvar g = 0; g < 3; g++) begin : g_dut
    dmem_responder #(.DEPTH(64), .LATENCY(g + 1)) u_dut (
      .clk       (clk),
      .reset     (rst_n[g]),
      .req_valid (req_valid[g]),
      .req_we    (req_we[g]),
      .req_byte  (req_byte[g]),
      .req_addr  (req_addr[g]),
      .req_wdata (req_wdata[g]),
      .req_ready (req_ready[g]),
      .rsp_valid (rsp_valid[g]),
      .rsp_rdata (rsp_rdata[g]),
      .busy      (busy[g])
    );
  end

  int total = 0;
  int bad   = 0;
  logic [31:0] mdl [3][64];
  logic [31:0] sbq [3][$];

  task automatic chk(input string tag, input logic [31:0] got,
                     input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  function automatic logic [31:0] mdl_ld(int k, logic byt, logic [31:0] a);
    logic [31:0] w;
    w = mdl[k][a[7:2]];
    if (byt && BE) return {24'h0, w[{a[1:0], 3'b000} +: 8]};
    return w;
  endfunction

  task automatic mdl_st(int k, logic byt, logic [31:0] a, logic [31:0] d);
    if (byt && BE) mdl[k][a[7:2]][{a[1:0], 3'b000} +: 8] = d[7:0];
    else           mdl[k][a[7:2]] = d;
  endtask

  always @(negedge clk) begin
    for (int k = 0; k < 3; k++) begin
      if (rst_n[k]) begin
        if (rsp_valid[k]) begin
          if (sbq[k].size() == 0) chk($sformatf("sb_extra%0d", k), 1, 0);
          else chk($sformatf("rdata%0d", k), rsp_rdata[k], sbq[k].pop_front());
        end else begin
          chk($sformatf("rd_idle%0d", k), rsp_rdata[k], 0);
        end
      end
    end
  end

  task automatic do_req(int k, logic we, logic byt, logic [31:0] a,
                        logic [31:0] d);
    int n;
    @(negedge clk);
    req_we[k] = we; req_byte[k] = byt;
    req_addr[k] = a; req_wdata[k] = d;
    req_valid[k] = 1'b1;
    n = 0;
    while (!req_ready[k] && n < 50) begin
      @(negedge clk);
      n++;
    end
    if (n >= 50) begin
      chk("ready_timeout", 0, 1);
      req_valid[k] = 1'b0;
      return;
    end
    sbq[k].push_back(we ? 32'h0 : mdl_ld(k, byt, a));
    if (we) mdl_st(k, byt, a, d);
    @(posedge clk);
    #1 req_valid[k] = 1'b0;
    n = 1;
    @(negedge clk);
    if (k > 0) begin
      chk($sformatf("busy%0d", k), 32'(busy[k]), 1);
      chk($sformatf("nrdy%0d", k), 32'(req_ready[k]), 0);
    end
    while (!rsp_valid[k] && n < 20) begin
      @(negedge clk);
      n++;
    end
    chk($sformatf("lat%0d", k), 32'(n), 32'(k + 1));
  endtask

  task automatic stream(int k, int ncyc, logic [31:0] base, int period,
                        int exp_acc);
    int acc;
    acc = 0;
    for (int i = 0; i < ncyc; i++) begin
      @(negedge clk);
      req_valid[k] = 1'b1; req_we[k] = 1'b0; req_byte[k] = 1'b0;
      req_addr[k] = base + 32'(4 * (i % 4));
      chk($sformatf("rdy_pat%0d_%0d", k, i), 32'(req_ready[k]),
          32'((i % period) == 0));
      if (req_ready[k]) begin
        acc++;
        sbq[k].push_back(mdl_ld(k, 1'b0, req_addr[k]));
      end
    end
    @(posedge clk);
    #1 req_valid[k] = 1'b0;
    chk($sformatf("accepts%0d", k), 32'(acc), 32'(exp_acc));
    repeat (period + 2) @(negedge clk);
  endtask

  initial begin
    int n;
    for (int k = 0; k < 3; k++) begin
      rst_n[k] = 1'b0; req_valid[k] = 1'b0; req_we[k] = 1'b0;
      req_byte[k] = 1'b0; req_addr[k] = '0; req_wdata[k] = '0;
    end
    repeat (2) @(negedge clk);
    for (int k = 0; k < 3; k++) begin
      chk("rst_ready", 32'(req_ready[k]), 1);
      chk("rst_busy", 32'(busy[k]), 0);
      chk("rst_valid", 32'(rsp_valid[k]), 0);
      chk("rst_rdata", rsp_rdata[k], 0);
      rst_n[k] = 1'b1;
    end

    do_req(1, 1, 0, 32'h10, 32'hDEADBEEF);
    do_req(1, 0, 0, 32'h10, 0);
    do_req(1, 1, 0, 32'h20, 32'h11223344);
    do_req(1, 1, 1, 32'h22, 32'hAA);
    do_req(1, 0, 0, 32'h20, 0);
    do_req(1, 0, 1, 32'h23, 0);
    do_req(1, 1, 0, 32'h100, 32'h5);
    do_req(1, 0, 0, 32'h0, 0);
    do_req(1, 0, 0, 32'h3, 0);

    do_req(0, 1, 0, 32'h4, 32'hCAFE0001);
    do_req(0, 0, 0, 32'h4, 0);
    for (int i = 0; i < 4; i++) begin
      do_req(2, 1, 0, 32'h40 + 32'(4 * i), 32'hA0 + 32'(i));
      do_req(0, 1, 0, 32'h40 + 32'(4 * i), 32'hB0 + 32'(i));
    end
    stream(2, 12, 32'h40, 4, 3);
    stream(0, 6, 32'h40, 2, 3);

    do_req(2, 1, 0, 32'h8, 32'h12);
    @(negedge clk);
    req_we[2] = 1'b1; req_byte[2] = 1'b0;
    req_addr[2] = 32'h8; req_wdata[2] = 32'h77;
    req_valid[2] = 1'b1;
    @(posedge clk);
    #1 req_valid[2] = 1'b0;
    @(negedge clk);
    chk("abort_busy_pre", 32'(busy[2]), 1);
    rst_n[2] = 1'b0;
    #1;
    chk("abort_valid", 32'(rsp_valid[2]), 0);
    chk("abort_busy", 32'(busy[2]), 0);
    chk("abort_rdata", rsp_rdata[2], 0);
    chk("abort_ready", 32'(req_ready[2]), 1);
    @(negedge clk);
    rst_n[2] = 1'b1;
    do_req(2, 0, 0, 32'h8, 0);

    n = 0;
    while ((sbq[0].size() + sbq[1].size() + sbq[2].size()) != 0 && n < 50) begin
      @(negedge clk);
      n++;
    end
    for (int k = 0; k < 3; k++)
      chk($sformatf("sb_left%0d", k), 32'(sbq[k].size()), 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
